// File: rtl/gf_asm_pkg.sv
// -----------------------------------------------------------------------------
// gf_asm_pkg
//   Shared definitions for the Galois-field packed-code assembler/disassembler
//   pair.
//
//   Packed code layout (W = SIZE/2, code is W+1 bits):
//     c[W]=1, c[W-1:0]=0  -> SPECIAL : both half flags set, all else zero
//     c[W]=1, c[W-1:0]!=0 -> ILLEGAL : expands to zero
//     c[W:W-1]=00         -> UPPER   : {c[W-1:0], W'b0}
//     c[W:W-1]=01         -> LOWER   : {1, 0.., 0, c[W-2:0]}
//
//   Contents:
//     kind_e     : classification of a packed code
//     half_w()   : derives the half width from SIZE
//     SIZE_DEF / WIDTH_DEF / OUT_DEF : the default geometry
//     gf_decode(): pure decode at the default geometry
//     gf_encode(): inverse of gf_decode for UPPER/LOWER/SPECIAL words
// -----------------------------------------------------------------------------
package gf_asm_pkg;

    typedef enum logic [1:0] {
        KIND_UPPER   = 2'd0,
        KIND_LOWER   = 2'd1,
        KIND_SPECIAL = 2'd2,
        KIND_ILLEGAL = 2'd3
    } kind_e;

    // SIZE must be even and at least 4 so that each half has a flag bit
    // plus at least one payload bit.
    function automatic int half_w(input int size);
        return size / 2;
    endfunction

    localparam int SIZE_DEF  = 6;
    localparam int WIDTH_DEF = half_w(SIZE_DEF);
    localparam int OUT_DEF   = WIDTH_DEF + 1;

    typedef struct packed {
        logic [SIZE_DEF-1:0] data;
        kind_e               kind;
    } dec_t;

    function automatic dec_t gf_decode(input logic [OUT_DEF-1:0] code);
        dec_t res;
        res.data = '0;
        res.kind = KIND_UPPER;
        if (code[WIDTH_DEF]) begin
            if (code[WIDTH_DEF-1:0] == '0) begin
                res.kind = KIND_SPECIAL;
                res.data = {1'b1, {(WIDTH_DEF-1){1'b0}}, 1'b1, {(WIDTH_DEF-1){1'b0}}};
            end else begin
                res.kind = KIND_ILLEGAL;
            end
        end else if (code[WIDTH_DEF-1]) begin
            res.kind = KIND_LOWER;
            res.data = {1'b1, {(WIDTH_DEF-1){1'b0}}, 1'b0, code[WIDTH_DEF-2:0]};
        end else begin
            res.data = {code[WIDTH_DEF-1:0], {WIDTH_DEF{1'b0}}};
        end
        return res;
    endfunction

    // Re-packs an expanded word. Only meaningful for words that came out of
    // gf_decode as UPPER, LOWER or SPECIAL; ILLEGAL information is lost.
    function automatic logic [OUT_DEF-1:0] gf_encode(input logic [SIZE_DEF-1:0] data);
        logic [SIZE_DEF-1:0] special_word;
        special_word = {1'b1, {(WIDTH_DEF-1){1'b0}}, 1'b1, {(WIDTH_DEF-1){1'b0}}};
        if (data == special_word) begin
            return {1'b1, {WIDTH_DEF{1'b0}}};
        end else if (data[SIZE_DEF-1]) begin
            return {2'b01, data[WIDTH_DEF-2:0]};
        end else begin
            return {1'b0, data[SIZE_DEF-1:WIDTH_DEF]};
        end
    endfunction

endpackage

// File: rtl/gf_dsm_decode.sv
// -----------------------------------------------------------------------------
// gf_dsm_decode
//   Purely combinational expansion of one packed GF code into a two-half word
//   and its kind.
//
//   Ports:
//     code : OUT-bit packed code
//     data : SIZE-bit expanded word (upper half = high field, lower = low)
//     kind : 0=UPPER 1=LOWER 2=SPECIAL 3=ILLEGAL
// -----------------------------------------------------------------------------
module gf_dsm_decode
    import gf_asm_pkg::*;
#(
    parameter  int SIZE  = 6,
    localparam int WIDTH = half_w(SIZE),
    localparam int OUT   = WIDTH + 1
) (
    input  logic [OUT-1:0]  code,
    output logic [SIZE-1:0] data,
    output logic [1:0]      kind
);

    always_comb begin
        data = '0;
        kind = KIND_UPPER;
        if (code[WIDTH]) begin
            // Top bit set: only the all-zero payload is a legal (SPECIAL) code.
            if (code[WIDTH-1:0] == '0) begin
                kind = KIND_SPECIAL;
                data = {1'b1, {(WIDTH-1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                kind = KIND_ILLEGAL;
            end
        end else if (code[WIDTH-1]) begin
            // LOWER: high half carries only its flag, low half flag is clear.
            kind = KIND_LOWER;
            data = {1'b1, {(WIDTH-1){1'b0}}, 1'b0, code[WIDTH-2:0]};
        end else begin
            data = {code[WIDTH-1:0], {WIDTH{1'b0}}};
        end
    end

endmodule

// File: rtl/gf_dsm.sv
// -----------------------------------------------------------------------------
// gf_dsm
//   Streaming disassembler for GF packed codes. Each accepted code is decoded
//   and presented one cycle later. A single output register plus one skid
//   register keep in_ready fully registered while sustaining 1 word/cycle.
//
//   Handshake: a word moves on a side exactly when valid && ready are high at
//   the rising clock edge; a producer holds valid and its payload until
//   accepted, and the output holds out_data/out_kind stable while
//   out_valid=1 and out_ready=0.
//
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     in_valid/in_ready     : packed-code input handshake
//     in_code               : OUT-bit packed code
//     out_valid/out_ready   : expanded-word output handshake
//     out_data              : SIZE-bit expanded word
//     out_kind              : 0=UPPER 1=LOWER 2=SPECIAL 3=ILLEGAL
//     err_sticky / err_clr  : ILLEGAL-seen flag and its synchronous clear
//     spec_cnt              : saturating count of accepted SPECIAL codes
// -----------------------------------------------------------------------------
module gf_dsm
    import gf_asm_pkg::*;
#(
    parameter  int SIZE  = 6,
    parameter  int CNT_W = 8,
    localparam int WIDTH = half_w(SIZE),
    localparam int OUT   = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT-1:0]   in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_data,
    output logic [1:0]       out_kind,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [CNT_W-1:0] spec_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SIZE-1:0] dec_data;
    logic [1:0]      dec_kind;

    logic            skid_valid;
    logic [SIZE-1:0] skid_data;
    logic [1:0]      skid_kind;

    logic in_fire;
    logic out_free;

    gf_dsm_decode #(.SIZE(SIZE)) u_decode (
        .code (in_code),
        .data (dec_data),
        .kind (dec_kind)
    );

    // in_ready comes straight from a flop: the skid slot is the only thing
    // that can refuse input, so out_ready never reaches in_ready.
    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && in_ready;
    // The output register can take a new word if it is empty or draining.
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_kind   <= KIND_UPPER;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_kind  <= KIND_UPPER;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    // The skid word is older than anything at the input.
                    // in_ready is low whenever the skid is full, so no input
                    // can be accepted in this cycle.
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_kind   <= skid_kind;
                    skid_valid <= 1'b0;
                end else if (in_fire) begin
                    out_valid <= 1'b1;
                    out_data  <= dec_data;
                    out_kind  <= dec_kind;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (in_fire) begin
                // Output is stalled: park the new word in the skid register.
                skid_valid <= 1'b1;
                skid_data  <= dec_data;
                skid_kind  <= dec_kind;
            end
        end
    end

    // An ILLEGAL acceptance in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (in_fire && (dec_kind == KIND_ILLEGAL)) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_cnt <= '0;
        end else if (in_fire && (dec_kind == KIND_SPECIAL) && (spec_cnt != CNT_MAX)) begin
            spec_cnt <= spec_cnt + CNT_ONE;
        end
    end

endmodule

// File: doc/gf_dsm.md
Name: gf_dsm

Overview:
- Streaming disassembler for the Galois-field packed code produced by the block's assembler counterpart.
- Expands each OUT-bit packed code back into a SIZE-bit two-half word: upper half = high field, lower half = low field, the MSB of each half is its flag.
- Sits on the read side of the GF datapath, between packed-code storage and the field arithmetic units.
- Uses a valid/ready handshake on both sides, has 1-cycle latency, and is fully pipelined with a skid buffer.

Parameters:
- SIZE, 6, width of the expanded word; must be even and ≥4.
- WIDTH, SIZE/2, width of one half (derived; do not override).
- OUT, SIZE/2+1, width of the packed code (derived).
- CNT_W, 8, width of the special-code counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  packed code valid.
- in_ready  output  1  block can accept a code.
- in_code  input  OUT  packed code.
- out_valid  output  1  expanded word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  SIZE  expanded word.
- out_kind  output  2  0=UPPER, 1=LOWER, 2=SPECIAL, 3=ILLEGAL.
- err_sticky  output  1  an ILLEGAL code has been accepted since the last clear.
- err_clr  input  1  synchronous clear of err_sticky.
- spec_cnt  output  CNT_W  number of SPECIAL codes accepted; saturating.

Behaviour:
- Decode, with W=WIDTH and c=in_code:
  - c[W]=1 and c[W-1:0]=0 → SPECIAL; out_data = {1,0..0, 1,0..0} (both flags set, all other bits 0).
  - c[W]=1 and c[W-1:0]≠0 → ILLEGAL; out_data = 0.
  - c[W:W-1]=00 → UPPER; out_data = {c[W-1:0], W'b0}.
  - c[W:W-1]=01 → LOWER; out_data = {1,(W-1)'b0, 1'b0, c[W-2:0]}.
- Transfer: occurs on each side when valid&&ready are both high.
- Latency: 1 cycle. An accepted code appears on out_data/out_kind with out_valid high on the next cycle.
- Skid buffer: one output register plus one skid register.
  - in_ready = !skid_full. It is registered and does not depend combinationally on out_ready.
  - If the output register is occupied and not drained while an input is accepted, the input goes to the skid register.
  - When the output register drains, skid contents move into it in the same cycle.
  - Throughput: 1 word/cycle while out_ready stays high.
- Ordering: strict FIFO. No word is dropped or duplicated under any out_ready pattern.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_kind hold stable.
- err_sticky:
  - Set on the cycle after an ILLEGAL code is accepted.
  - err_clr has priority only if no ILLEGAL code is accepted in the same cycle; a simultaneous ILLEGAL acceptance wins and the flag stays set.
- spec_cnt:
  - Increments on acceptance of a SPECIAL code.
  - Saturates at 2^CNT_W-1; no wrap.
- ILLEGAL words still travel the pipeline, with kind=3 and data 0.
- Reset values: out_valid=0, in_ready=1 (on the first cycle after release), out_data=0, out_kind=0, err_sticky=0, spec_cnt=0; skid buffer empty.
- Reset mid-transfer: asserting rst discards both buffered words immediately (asynchronous). No partial output appears after release.

Decomposition:
- Shared package gf_asm_pkg holds:
  - the kind enum (KIND_UPPER, KIND_LOWER, KIND_SPECIAL, KIND_ILLEGAL);
  - the localparam derivations WIDTH/OUT from SIZE;
  - a pure decode function, so the assembler bench can reuse it for round-trip checks.
- One combinational sub-module gf_dsm_decode: in_code → {out_data, out_kind}.
- gf_dsm itself holds the skid/output registers, err_sticky and spec_cnt.

Test Plan:
All values at SIZE=6.
- Reset, then in_code=4'b1000 with in_valid=1 and out_ready=1 → next cycle out_data=6'b100100, out_kind=2, spec_cnt=1.
- in_code=4'b0011 → out_data=6'b011000, kind 0. in_code=4'b0110 → out_data=6'b100010, kind 1. Both back-to-back, 1 word/cycle.
- in_code=4'b1010 → out_data=0, kind 3, err_sticky=1 the following cycle. Then err_clr=1 alone → err_sticky=0. Then err_clr together with another 4'b1010 accepted → err_sticky stays 1.
- Stream 0000,0001,0101,1000 with out_ready=0 → in_ready drops after 2 accepted. Release out_ready → all four emerge in order, and out_data holds stable while stalled.
- Random in_valid/out_ready for 10k codes → output sequence equals the reference decode of the accepted inputs; the assembler(disassembler(c)) round-trip matches for UPPER/SPECIAL codes.
- Set CNT_W=2 and feed 5 SPECIAL codes → spec_cnt saturates at 3. Pulse rst while two words are buffered → out_valid=0 immediately, and nothing emerges afterward.
